// File: rtl/onehot_decoder_pipe.sv
// ---------------------------------------------------------------------------
// onehot_decoder_pipe
//
// Registered N-to-2^N one-hot line decoder used to generate per-register
// write-enable lines for the register file. A request is taken with a
// valid/ready handshake and the decoded word appears one cycle later with
// a single-cycle out_valid strobe. Back-to-back requests are accepted every
// cycle; there is no downstream backpressure.
//
// Optional sweep mode (compile macro DECODER_SWEEP_EN): a sweep_start
// request walks every output line once, one line per cycle, so the whole
// register file can be cleared after boot. Without the macro the block is
// a pure decoder: sweep_start is ignored, busy/sweep_done are tied low and
// in_ready is permanently high.
//
// Parameters:
//   SEL_W      select width; OUT_W = 2**SEL_W output lines (derived).
//   ZERO_LINE  when 1, line 0 is never asserted (hardwired-zero R0).
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   in_valid     decode request present
//   in_ready     combinational; request taken on an edge with valid&&ready
//   sel          line to decode
//   en           0 turns an accepted request into an all-zero word
//   sweep_start  request a full sweep (sweep build only)
//   out_valid    registered one-cycle strobe per produced word
//   out_lines    registered one-hot (or all-zero) word
//   busy         registered, high while a sweep is running
//   sweep_done   registered pulse together with the last sweep word
// ---------------------------------------------------------------------------
module onehot_decoder_pipe #(
  parameter  int SEL_W     = 5,
  parameter  int ZERO_LINE = 1,
  localparam int OUT_W     = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  input  logic             sweep_start,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_lines,
  output logic             busy,
  output logic             sweep_done
);

  // One-hot word for a line index, with line 0 suppressed when R0 is
  // hardwired to zero. Shared by the decode path and the sweep walker so
  // the masking rule cannot diverge between the two.
  function automatic logic [OUT_W-1:0] line_of(input logic [SEL_W-1:0] idx);
    logic [OUT_W-1:0] word;
    word      = {OUT_W{1'b0}};
    word[idx] = 1'b1;
    if (ZERO_LINE != 0) begin
      word[0] = 1'b0;
    end else begin
      word[0] = word[0];
    end
    return word;
  endfunction

  logic             out_valid_r;
  logic [OUT_W-1:0] out_lines_r;
  logic [OUT_W-1:0] decode_s;
  logic             accept_s;

  // Word produced by an accepted request; en=0 yields an all-zero word.
  always_comb begin
    decode_s = {OUT_W{1'b0}};
    if (en) begin
      decode_s = line_of(sel);
    end else begin
      decode_s = {OUT_W{1'b0}};
    end
  end

  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign out_lines = out_lines_r;

`ifdef DECODER_SWEEP_EN

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] CNT_LAST = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0] CNT_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [SEL_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;

  // sweep_start wins over a same-cycle decode request, so ready drops as
  // soon as a sweep is requested, not only once the sweep is running.
  assign in_ready   = (state_r == ST_IDLE) && !sweep_start;
  assign busy       = busy_r;
  assign sweep_done = done_r;

  // Decode/sweep FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {SEL_W{1'b0}};
      out_valid_r <= 1'b0;
      out_lines_r <= {OUT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (sweep_start) begin
            // Entry edge produces no word; line 0 follows on the next edge.
            state_r     <= ST_SWEEP;
            cnt_r       <= {SEL_W{1'b0}};
            busy_r      <= 1'b1;
            out_valid_r <= 1'b0;
          end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_lines_r <= decode_s;
          end else begin
            // No request: strobe drops, last word is held.
            out_valid_r <= 1'b0;
          end
        end
        ST_SWEEP: begin
          out_lines_r <= line_of(cnt_r);
          out_valid_r <= 1'b1;
          // Counter wraps to zero by width after the last line.
          cnt_r       <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= {SEL_W{1'b0}};
          out_valid_r <= 1'b0;
          out_lines_r <= {OUT_W{1'b0}};
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

`else

  logic unused_sweep_s;

  // Decoder-only build: always ready, sweep request has no effect.
  assign in_ready       = 1'b1;
  assign busy           = 1'b0;
  assign sweep_done     = 1'b0;
  assign unused_sweep_s = sweep_start;

  // Decode register: capture on accept, otherwise drop strobe and hold word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_lines_r <= {OUT_W{1'b0}};
    end else begin
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_lines_r <= decode_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

`endif

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
`timescale 1ns/1ps
module tb_onehot_decoder_pipe;

`ifdef DECODER_SWEEP_EN
  localparam bit SWEEP_BUILD = 1'b1;
`else
  localparam bit SWEEP_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        en;
  logic        sweep_start;
  logic [4:0]  sel;

  logic        rdy0, rdy1, ov0, ov1, busy0, busy1, done0, done1;
  logic [31:0] ol0, ol1;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: last expected strobe and held words per instance
  logic        exp_v;
  logic [31:0] exp_l0, exp_l1;

  always #5 clk = ~clk;

  onehot_decoder_pipe #(.SEL_W(5), .ZERO_LINE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .sel(sel),
    .en(en), .sweep_start(sweep_start), .out_valid(ov0), .out_lines(ol0),
    .busy(busy0), .sweep_done(done0));

  onehot_decoder_pipe #(.SEL_W(5), .ZERO_LINE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .sel(sel),
    .en(en), .sweep_start(sweep_start), .out_valid(ov1), .out_lines(ol1),
    .busy(busy1), .sweep_done(done1));

  // Expected decoded word from the rules: 2**s, zero if disabled or masked R0.
  function automatic logic [31:0] ref_word(input int s, input bit e, input bit zl);
    logic [31:0] w;
    if (!e || (zl && s == 0)) w = 32'd0;
    else                      w = 32'd1 << s;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance the model by one edge while the block is idle.
  task automatic model_edge();
    if (in_valid && !(SWEEP_BUILD && sweep_start)) begin
      exp_v  = 1'b1;
      exp_l0 = ref_word(int'(sel), en, 1'b0);
      exp_l1 = ref_word(int'(sel), en, 1'b1);
    end else begin
      exp_v = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; en = 1'b0; sweep_start = 1'b0; sel = 5'd0;
    #1;
    n_cmp++;
    if ({ov0, ov1, ol0, ol1, busy0, busy1, done0, done1, rdy0, rdy1} !==
        {1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 2'b11}) begin
      n_bad++;
      $display("FAIL reset_async: v=%b%b l0=%h l1=%h busy=%b%b done=%b%b rdy=%b%b, want zeros and rdy=11",
               ov0, ov1, ol0, ol1, busy0, busy1, done0, done1, rdy0, rdy1);
    end
    tick(); tick();
    rst = 1'b0;
    exp_v = 1'b0; exp_l0 = 32'd0; exp_l1 = 32'd0;
    tick();
    n_cmp++;
    if ({ov0, ov1, ol0, ol1} !== {2'b00, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL reset_idle: v=%b%b l0=%h l1=%h, want all zero", ov0, ov1, ol0, ol1);
    end
  endtask

  task automatic test_decode_seq();
    int sels [4] = '{0, 1, 2, 31};
    logic [31:0] want0 [4] = '{32'h1, 32'h2, 32'h4, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; en = 1'b1; sel = 5'(sels[i]);
      model_edge();
      tick();
      n_cmp++;
      if ({ov0, ol0, ov1, ol1} !== {1'b1, want0[i], 1'b1, exp_l1}) begin
        n_bad++;
        $display("FAIL decode_seq[%0d]: v0=%b l0=%h v1=%b l1=%h, want v=1 l0=%h l1=%h",
                 i, ov0, ol0, ov1, ol1, want0[i], exp_l1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_zero_line();
    int sels [3] = '{0, 3, 5};
    bit ens  [3] = '{1'b1, 1'b0, 1'b1};
    bit vals [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      in_valid = vals[i]; en = ens[i]; sel = 5'(sels[i]);
      model_edge();
      tick();
      n_cmp++;
      if ({ov0, ol0, ov1, ol1} !== {exp_v, exp_l0, exp_v, exp_l1}) begin
        n_bad++;
        $display("FAIL zero_line[%0d]: v0=%b l0=%h v1=%b l1=%h, want v=%b l0=%h l1=%h",
                 i, ov0, ol0, ov1, ol1, exp_v, exp_l0, exp_l1);
      end
    end
  endtask

  task automatic test_random(input int cycles, input bit hold_sweep);
    for (int i = 0; i < cycles; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      en          = ($urandom_range(0, 4) != 0);
      sel         = 5'($urandom_range(0, 31));
      sweep_start = hold_sweep;
      #1;
      n_cmp++;
      if ({rdy0, rdy1} !== 2'b11) begin
        n_bad++;
        $display("FAIL random_ready[%0d]: rdy=%b%b, want 11", i, rdy0, rdy1);
      end
      model_edge();
      tick();
      n_cmp++;
      if ({ov0, ol0, ov1, ol1, busy0, busy1, done0, done1} !==
          {exp_v, exp_l0, exp_v, exp_l1, 4'b0000}) begin
        n_bad++;
        $display("FAIL random[%0d]: v0=%b l0=%h v1=%b l1=%h busy=%b%b done=%b%b, want v=%b l0=%h l1=%h busy/done 0",
                 i, ov0, ol0, ov1, ol1, busy0, busy1, done0, done1, exp_v, exp_l0, exp_l1);
      end
    end
    in_valid = 1'b0; sweep_start = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; en = 1'b1; sel = 5'd9;
    model_edge();
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (ol0 !== 32'h200) begin
      n_bad++;
      $display("FAIL areset_pre: l0=%h, want 00000200", ol0);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ov0, ov1, ol0, ol1, busy0, done0, rdy0, rdy1} !== {2'b00, 32'd0, 32'd0, 2'b00, 2'b11}) begin
      n_bad++;
      $display("FAIL areset_now: v=%b%b l0=%h l1=%h busy=%b done=%b rdy=%b%b, want zeros rdy=11",
               ov0, ov1, ol0, ol1, busy0, done0, rdy0, rdy1);
    end
    #1 rst = 1'b0;
    exp_v = 1'b0; exp_l0 = 32'd0; exp_l1 = 32'd0;
    in_valid = 1'b1; en = 1'b1; sel = 5'd4;
    model_edge();
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({ov0, ol0, ol1} !== {1'b1, 32'h10, 32'h10}) begin
      n_bad++;
      $display("FAIL areset_post: v=%b l0=%h l1=%h, want v=1 l=00000010", ov0, ol0, ol1);
    end
  endtask

`ifdef DECODER_SWEEP_EN
  task automatic test_sweep();
    int busy_cnt = 0;
    in_valid = 1'b0; sweep_start = 1'b1;
    #1;
    n_cmp++;
    if ({rdy0, rdy1} !== 2'b00) begin
      n_bad++;
      $display("FAIL sweep_req_ready: rdy=%b%b, want 00", rdy0, rdy1);
    end
    tick();
    sweep_start = 1'b0;
    n_cmp++;
    if ({ov0, busy0, busy1, done0} !== 4'b0110) begin
      n_bad++;
      $display("FAIL sweep_entry: v=%b busy=%b%b done=%b, want v=0 busy=11 done=0", ov0, busy0, busy1, done0);
    end
    for (int k = 0; k < 32; k++) begin
      if (busy0) busy_cnt++;
      n_cmp++;
      if ({rdy0, rdy1} !== 2'b00) begin
        n_bad++;
        $display("FAIL sweep_ready[%0d]: rdy=%b%b, want 00", k, rdy0, rdy1);
      end
      tick();
      n_cmp++;
      if ({ov0, ov1, ol0, ol1, done0, done1, busy0, busy1} !==
          {2'b11, ref_word(k, 1'b1, 1'b0), ref_word(k, 1'b1, 1'b1),
           {2{k == 31}}, {2{k != 31}}}) begin
        n_bad++;
        $display("FAIL sweep_line[%0d]: v=%b%b l0=%h l1=%h done=%b%b busy=%b%b, want l0=%h l1=%h done=%0d busy=%0d",
                 k, ov0, ov1, ol0, ol1, done0, done1, busy0, busy1,
                 ref_word(k, 1'b1, 1'b0), ref_word(k, 1'b1, 1'b1), k == 31, k != 31);
      end
    end
    n_cmp++;
    if (busy_cnt != 32) begin
      n_bad++;
      $display("FAIL sweep_busy_len: %0d cycles, want 32", busy_cnt);
    end
    exp_v = 1'b0; exp_l0 = 32'h8000_0000; exp_l1 = 32'h8000_0000;
    tick();
    n_cmp++;
    if ({ov0, done0, rdy0, ol0} !== {3'b001, exp_l0}) begin
      n_bad++;
      $display("FAIL sweep_exit: v=%b done=%b rdy=%b l0=%h, want v=0 done=0 rdy=1 l0=%h",
               ov0, done0, rdy0, ol0, exp_l0);
    end
  endtask

  task automatic test_sweep_priority();
    sweep_start = 1'b1; in_valid = 1'b1; sel = 5'd7; en = 1'b1;
    #1;
    n_cmp++;
    if (rdy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_ready: rdy=%b, want 0", rdy0);
    end
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 32; k++) tick();
    n_cmp++;
    if ({ol0, done0, rdy0} !== {32'h8000_0000, 2'b11}) begin
      n_bad++;
      $display("FAIL prio_last: l0=%h done=%b rdy=%b, want 80000000 done=1 rdy=1", ol0, done0, rdy0);
    end
    model_edge();
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({ov0, ol0, ov1, ol1} !== {1'b1, 32'h80, 1'b1, 32'h80}) begin
      n_bad++;
      $display("FAIL prio_decode: v0=%b l0=%h v1=%b l1=%h, want v=1 l=00000080", ov0, ol0, ov1, ol1);
    end
  endtask

  task automatic test_sweep_reset();
    sweep_start = 1'b1; in_valid = 1'b0;
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 11; k++) tick();
    n_cmp++;
    if ({ol0, busy0} !== {32'h400, 1'b1}) begin
      n_bad++;
      $display("FAIL sreset_pre: l0=%h busy=%b, want 00000400 busy=1", ol0, busy0);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ov0, ol0, ol1, busy0, busy1, done0, rdy0, rdy1} !== {1'b0, 32'd0, 32'd0, 3'b000, 2'b11}) begin
      n_bad++;
      $display("FAIL sreset_now: v=%b l0=%h l1=%h busy=%b%b done=%b rdy=%b%b, want zeros rdy=11",
               ov0, ol0, ol1, busy0, busy1, done0, rdy0, rdy1);
    end
    #1 rst = 1'b0;
    in_valid = 1'b1; en = 1'b1; sel = 5'd4;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({ov0, ol0, busy0} !== {1'b1, 32'h10, 1'b0}) begin
      n_bad++;
      $display("FAIL sreset_post: v=%b l0=%h busy=%b, want v=1 l0=00000010 busy=0", ov0, ol0, busy0);
    end
    exp_v = 1'b1; exp_l0 = 32'h10; exp_l1 = 32'h10;
  endtask
`else
  task automatic test_sweep_ignored();
    test_random(40, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_decode_seq();
    test_zero_line();
    test_random(300, 1'b0);
    test_async_reset();
`ifdef DECODER_SWEEP_EN
    test_sweep();
    test_sweep_priority();
    test_sweep_reset();
`else
    test_sweep_ignored();
`endif
    test_random(50, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_pipe.md
# onehot_decoder_pipe

Parametrised, registered N-to-2^N one-hot line decoder with a valid/ready input handshake and an optional self-timed sweep mode. It generates per-register write-enable lines for the register file and replaces the purely combinational 5-to-32 decoder in the datapath. The sweep mode walks every output line once, one line per cycle, and is used to clear the register file after boot.

## Interface
Parameters:
- SEL_W, 5, select width; OUT_W = 2**SEL_W output lines (derived, not overridable).
- ZERO_LINE, 1, when 1, line 0 is never asserted (hardwired-zero register R0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode request present.
- in_ready  out  1  combinational; request accepted on a clk edge where in_valid && in_ready.
- sel  in  SEL_W  line to decode.
- en  in  1  when 0, an accepted request produces all-zero lines (out_valid still pulses).
- sweep_start  in  1  request a full sweep (sweep build only).
- out_valid  out  1  registered; high for exactly one cycle per produced output word.
- out_lines  out  OUT_W  registered one-hot, or all-zero, decode result.
- busy  out  1  registered; high while a sweep is in progress.
- sweep_done  out  1  registered; single-cycle pulse coincident with the last sweep output.

## Operation
- States: IDLE and SWEEP. SWEEP exists only with the configuration macro.
- in_ready = (state == IDLE) && !sweep_start. sweep_start has priority over in_valid in the same cycle.
- Decode: on an accepting edge, out_lines <= en ? (1 << sel) : 0, and out_valid <= 1. Otherwise, in IDLE, out_valid <= 0 and out_lines holds its value.
- There is no downstream backpressure. A decode can be accepted every cycle, giving back-to-back out_valid.
- ZERO_LINE = 1 masks bit 0 of out_lines in all modes. For sel = 0, out_lines = 0 and out_valid = 1.
- Sweep start: sweep_start high in IDLE moves the block to SWEEP, sets cnt <= 0 and busy <= 1. On this edge out_valid <= 0.
- Each edge in SWEEP: out_lines <= 1 << cnt (masked per ZERO_LINE), out_valid <= 1, cnt <= cnt + 1.
- When cnt == OUT_W-1 on that edge: sweep_done <= 1, busy <= 0, state <= IDLE. cnt wraps to 0 naturally at SEL_W bits.
- sweep_start, in_valid, sel and en are ignored during SWEEP.
- Reset, including mid-sweep: state IDLE, cnt 0, out_valid 0, out_lines 0, busy 0, sweep_done 0. in_ready returns to 1 immediately.

## Timing
- Decode latency is 1 cycle, accept edge to out_valid/out_lines. Throughput is 1 per cycle.
- Sweep timeline, with sweep_start accepted at edge E0:
  - Line k is presented after edge E(k+1), for k = 0..OUT_W-1.
  - sweep_done and the last line appear together after edge E(OUT_W).
  - busy is high from E0 to E(OUT_W).
  - in_ready is low from E0 up to E(OUT_W); the first new decode is accepted at edge E(OUT_W+1) at the earliest.
- sweep_done, out_valid and busy are registered and glitch-free. in_ready is the only combinational output.

## Configuration
- DECODER_SWEEP_EN defined: the SWEEP state, the cnt counter and the sweep_start/busy/sweep_done behaviour are present as described above.
- DECODER_SWEEP_EN undefined: the block is IDLE-only. sweep_start is ignored, busy and sweep_done are tied 0, and in_ready = 1 permanently. Decode behaviour is identical in both builds.

## Test plan
- SEL_W=5, ZERO_LINE=0, en=1, sel = 0, 1, 2, 31 on consecutive cycles -> out_lines = 0x1, 0x2, 0x4, 0x80000000 on the following consecutive cycles, with out_valid continuously high.
- ZERO_LINE=1, sel=0, en=1 -> out_lines = 0, out_valid = 1; sel=3, en=0 -> out_lines = 0, out_valid = 1.
- Sweep build, sweep_start pulse -> 32 consecutive out_valid cycles with out_lines = 1<<k for k = 0..31 (bit 0 masked if ZERO_LINE=1). sweep_done is high only with 0x80000000, and busy is high for 32 cycles.
- sweep_start and in_valid (sel=7) in the same cycle -> decode not accepted (in_ready = 0) and sweep proceeds. sel=7 held with in_valid high is accepted at E33, giving out_lines = 0x80 one cycle later.
- rst asserted asynchronously after line 10 of a sweep -> all outputs 0 with no clock edge needed, in_ready = 1. A following decode of sel=4 gives out_lines = 0x10.
- Non-sweep build: sweep_start held high -> in_ready stays 1, busy = sweep_done = 0, and decodes are unaffected.
